// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand/opcode beat in, flagged result out.
// The master side drives operands and accepts results; the slave side is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             zero;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, opcode, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, result, zero, op_count
  );

  modport slave (
    input  in_valid, a, b, opcode, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, result, zero, op_count
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, an accumulator
// usable as operand A, carry/borrow/overflow + zero flags and a handshake counter.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_NOT  = 3'd4,
    OP_MUL  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             acc_sel;
  } s1_t;

  s1_t                s1_q, s1_d;
  logic               s1_valid_q, s1_valid_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   opa;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     alu_res;
  logic               in_fire, out_fire, s2_load;

  assign out_fire     = out_valid_q && bus.out_ready;
  assign s2_load      = s1_valid_q && (!out_valid_q || bus.out_ready);
  // Ready is held low during reset so no beat is taken while state is being cleared.
  assign bus.in_ready = !rst && (!s1_valid_q || s2_load);
  assign in_fire      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.op_count  = cnt_q;

  // Accumulator is read here, at S2 time, so a dependent op directly behind
  // an accumulate sees the freshly written value.
  always_comb begin
    opa     = s1_q.acc_sel ? acc_q : s1_q.a;
    prod    = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, s1_q.b};
    alu_res = '0;
    case (s1_q.op)
      OP_ADD:  alu_res = {1'b0, opa} + {1'b0, s1_q.b};
      OP_SUB:  alu_res = {1'b0, opa} - {1'b0, s1_q.b};
      OP_AND:  alu_res = {1'b0, opa & s1_q.b};
      OP_OR:   alu_res = {1'b0, opa | s1_q.b};
      OP_NOT:  alu_res = {1'b0, ~opa};
      OP_MUL:  alu_res = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
      OP_XOR:  alu_res = {1'b0, opa ^ s1_q.b};
      OP_XNOR: alu_res = {1'b0, ~(opa ^ s1_q.b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q + CNT_W'(out_fire);

    if (in_fire) begin
      s1_d.a     = bus.a;
      s1_d.b     = bus.b;
      s1_d.op    = op_e'(bus.opcode);
      s1_d.acc_sel = bus.acc_sel;
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res[WIDTH-1:0] == '0);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over the write-back of a result loading in the same cycle.
    if (bus.acc_clr)
      acc_d = '0;
    else if (s2_load)
      acc_d = alu_res[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU; successor to the 4-bit combinational operation unit.
- Adds configurable operand width, valid/ready handshaking with backpressure, and an internal accumulator usable as operand A.
- Adds carry/borrow and zero flags, and a wrapping count of completed operations.
- Sits between an instruction/operand source and a result consumer; either side may stall.

Parameters:
- WIDTH, 8, operand width in bits (>=2); result is WIDTH+1 bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/opcode beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A (ignored when acc_sel=1).
- b  input  WIDTH  operand B.
- opcode  input  3  0 add, 1 sub, 2 and, 3 or, 4 not, 5 mul, 6 xor, 7 xnor.
- acc_sel  input  1  use accumulator instead of a as operand A.
- acc_clr  input  1  synchronous accumulator clear.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH+1  bit WIDTH = carry/borrow/overflow flag; low WIDTH bits = value.
- zero  output  1  result[WIDTH-1:0]==0, registered with result.
- op_count  output  CNT_W  number of output handshakes, wraps.

Behaviour:
- Reset (async, rst=1): s1_valid=0, out_valid=0, result=0, zero=0, acc=0, op_count=0.
- in_ready is 0 while rst is asserted.
- Stage 1 (S1) registers a, b, opcode, acc_sel on input handshake (in_valid && in_ready).
- Stage 2 (S2) computes from S1 contents into the output register.
- s2_load = s1_valid && (!out_valid || out_ready).
- in_ready = !s1_valid || s2_load; combinational, with no dependency on in_valid.
- Latency: a beat accepted at edge N produces out_valid=1 after edge N+1. Throughput is 1 beat/cycle when out_ready=1.
- out_valid, result and zero hold stable while out_valid && !out_ready.
- out_valid clears on an output handshake with no s2_load in the same cycle.
- Operand A in S2 = acc if the S1 acc_sel is set, else the S1 a. The accumulator is read at S2 time, so back-to-back accumulate ops see the immediately preceding result (no hazard).
- Arithmetic, all WIDTH+1 bits:
  - add: zero-extended A+B; bit WIDTH is carry.
  - sub: zero-extended A-B; bit WIDTH=1 iff A<B (borrow). Value is two's-complement wrap.
  - and/or/xor/xnor: bitwise on WIDTH bits; bit WIDTH=0.
  - not: ~A; bit WIDTH=0.
  - mul: low WIDTH bits of A*B; bit WIDTH=1 iff the upper WIDTH bits of the full product are nonzero.
- Accumulator:
  - On s2_load, acc <= new result[WIDTH-1:0].
  - acc_clr=1 forces acc <= 0 and takes priority over a coincident s2_load update. The result register itself still loads normally.
- op_count increments by 1 on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - Input accept and output handshake in the same cycle: both occur and the pipeline advances.
  - A full pipeline with out_ready=0 holds exactly 2 beats (S1 + output); in_ready=0.
- Reset asserted mid-operation discards in-flight beats immediately. No output handshake is reported for them and op_count does not count them.

Test Plan:
- WIDTH=8, add a=200 b=100, out_ready=1 -> two cycles later out_valid=1, result=9'h12C, zero=0, op_count=1.
- sub a=5 b=7 -> result=9'h1FE (borrow=1, value 0xFE); sub a=7 b=7 -> result=9'h000, zero=1.
- mul a=16 b=16 -> result=9'h100 (overflow=1, value 0), zero=1; mul a=15 b=17 -> result=9'h0FF.
- acc_clr pulse, then three beats add acc_sel=1 b=5 back-to-back -> results 5, 10, 15 on consecutive cycles; 4th beat with acc_clr=1 coincident with S2 load -> that result is 20, next acc-based add b=1 gives 1.
- out_ready=0, send beats 1,2,3 -> beats 1,2 accepted, in_ready=0 on beat 3, result stable; raise out_ready -> outputs 1,2,3 in order, op_count=3.
- Assert rst with 2 beats in flight -> out_valid=0, result=0, op_count=0, acc=0 immediately (asynchronously); first beat after release completes normally.
